// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS32 memory arbiter.
//   arb_state_e : arbiter sequencing states (IDLE / ACCESS / RESP)
//   owner_e     : which port owns the current RAM command (IF or DM)
//   *_DEF       : default widths shared with the pipeline top
package mips_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational winner select and starvation-counter update.
// Ports:
//   eff_if_i       IF request already masked by halted
//   dm_req_i       MEM-stage request
//   starve_cnt_i   current count of DM wins while IF waited
//   pick_valid_o   some port requests this cycle
//   pick_owner_o   winning port (meaningful when pick_valid_o)
//   starve_d_o     next starvation count
module mips_arb_pick
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             eff_if_i,
  input  logic             dm_req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             pick_valid_o,
  output owner_e           pick_owner_o,
  output logic [CNT_W-1:0] starve_d_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic force_if;

  always_comb begin
    force_if     = eff_if_i && (starve_cnt_i == CNT_MAX);
    pick_valid_o = eff_if_i || dm_req_i;
    pick_owner_o = (dm_req_i && !force_if) ? OWN_DM : OWN_IF;
    starve_d_o   = '0;
    // Only a DM win that leaves IF waiting counts toward starvation.
    if (dm_req_i && !force_if && eff_if_i) begin
      starve_d_o = (starve_cnt_i == CNT_MAX) ? CNT_MAX : starve_cnt_i + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter for the single-port unified I/D RAM. MEM (DM) has priority over IF;
// after STARVE_MAX consecutive DM wins with IF waiting, IF is forced through.
// Ports:
//   clk1, rst_n                 clock, synchronous active-low reset
//   if_req/if_addr/if_flush     IF fetch request, address, branch flush
//   if_gnt/if_rvalid/if_rdata   IF grant pulse, read-valid pulse, instruction
//   dm_req/dm_we/dm_addr/dm_wdata  MEM-stage request
//   dm_gnt/dm_rvalid/dm_rdata   DM grant pulse, read-valid pulse, load data
//   halted                      blocks new IF grants
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM interface
//
// state  | meaning
// IDLE   | arbitrate, latch winner's command
// ACCESS | command on RAM, owner's gnt pulses
// RESP   | read data returned to owner
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              pick_valid;
  owner_e            pick_owner;
  logic [CNT_W-1:0]  pick_starve;

  mips_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .eff_if_i     (if_req && !halted),
    .dm_req_i     (dm_req),
    .starve_cnt_i (starve_q),
    .pick_valid_o (pick_valid),
    .pick_owner_o (pick_owner),
    .starve_d_o   (pick_starve)
  );

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      flush_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      flush_q    <= flush_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    flush_d    = flush_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        flush_d  = 1'b0;
        starve_d = pick_starve;
        if (pick_valid) begin
          owner_d = pick_owner;
          state_d = ST_ACCESS;
          if (pick_owner == OWN_DM) begin
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        // Remember a flush seen while the IF read is on the RAM.
        if (owner_q == OWN_IF && if_flush) flush_d = 1'b1;
        state_d = we_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
        else                   dm_rdata_d = mem_rdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated by rst_n so a reset cycle never writes RAM or pulses gnt/rvalid.
  logic in_access, in_resp;

  always_comb begin
    in_access = rst_n && (state_q == ST_ACCESS);
    in_resp   = rst_n && (state_q == ST_RESP);
    mem_en    = in_access;
    mem_we    = in_access && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_gnt    = in_access && (owner_q == OWN_IF);
    dm_gnt    = in_access && (owner_q == OWN_DM);
    if_rvalid = in_resp && (owner_q == OWN_IF) && !flush_q && !if_flush;
    dm_rvalid = in_resp && (owner_q == OWN_DM);
    if_rdata  = (in_resp && owner_q == OWN_IF) ? mem_rdata : if_rdata_q;
    dm_rdata  = (in_resp && owner_q == OWN_DM) ? mem_rdata : dm_rdata_q;
  end

endmodule
